// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared types and sizing helpers for the serial Montgomery multiplier
package mont_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOOP  = 2'd1,
        FINAL = 2'd2
    } mont_state_t;

    // Bits needed to count 0..width-1 (never less than one bit).
    function automatic int cnt_width(input int width);
        int w;
        w = 1;
        while ((1 << w) < width) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/montgomery_mult_serial_rca.sv
// rtl/montgomery_mult_serial_rca.sv - parameterised ripple-carry adder used by the Montgomery multiplier
// Ports:
//   a, b  in  W   addends
//   ci    in  1   carry in
//   s     out W   sum
//   co    out 1   carry out
module ripple_carry_adder #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar k = 0; k < W; k++) begin : g_fa
        assign s[k]   = a[k] ^ b[k] ^ c[k];
        assign c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
    end

    assign co = c[W];

endmodule

// File: rtl/montgomery_mult_serial.sv
// rtl/montgomery_mult_serial.sv - bit-serial Montgomery multiplier, result = a*b*2^-WIDTH mod n
// Ports:
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request, sampled only while idle
//   a, b, n in   WIDTH  multiplicand, multiplier, odd modulus (captured on accepted start)
//   busy    out  1      multiplication in progress
//   done    out  1      one-cycle pulse, result valid
//   err     out  1      pulses with done when the request was rejected
//   result  out  WIDTH  Montgomery product, held until the next accepted start
// Optional feature macro: MONT_MOD_CHECK_EN rejects an even modulus immediately.
module montgomery_mult_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    import mont_pkg::*;

    localparam int RW = WIDTH + 2;
    localparam int CW = cnt_width(WIDTH);

    mont_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CW-1:0]    i_q, i_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             a_bit;
    logic             q_bit;
    logic [RW-1:0]    add_b_in, add_n_in, sub_in;
    logic [RW-1:0]    sum_b, sum_n, diff;
    logic             co_b, co_n, no_borrow;
    logic             reject;

    assign a_bit    = a_q[i_q];
    // Quotient bit chosen so that R + a_i*b + q*n is even.
    assign q_bit    = r_q[0] ^ (a_bit & b_q[0]);
    assign add_b_in = a_bit ? {2'b00, b_q} : '0;
    assign add_n_in = q_bit ? {2'b00, n_q} : '0;
    assign sub_in   = ~{2'b00, n_q};

    ripple_carry_adder #(.W(RW)) u_add_b (
        .a (r_q),   .b (add_b_in), .ci (1'b0), .s (sum_b), .co (co_b)
    );

    ripple_carry_adder #(.W(RW)) u_add_n (
        .a (sum_b), .b (add_n_in), .ci (1'b0), .s (sum_n), .co (co_n)
    );

    // R - n as R + ~n + 1; carry out high means no borrow (R >= n).
    ripple_carry_adder #(.W(RW)) u_sub_n (
        .a (r_q),   .b (sub_in),   .ci (1'b1), .s (diff),  .co (no_borrow)
    );

`ifdef MONT_MOD_CHECK_EN
    assign reject = ~n[0];
`else
    assign reject = 1'b0;
`endif

    // Carries out of the loop adders cannot be set while R < 2n; sum_n[0] is always 0.
    logic unused_bits;
    assign unused_bits = ^{co_b, co_n, sum_n[0], diff[RW-1:WIDTH]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        r_d      = r_q;
        i_d      = i_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d = a;
                    b_d = b;
                    n_d = n;
                    r_d = '0;
                    i_d = '0;
                    if (reject) begin
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        result_d = '0;
                    end else begin
                        state_d = LOOP;
                        busy_d  = 1'b1;
                    end
                end
            end
            LOOP: begin
                r_d = {1'b0, sum_n[RW-1:1]};
                i_d = i_q + CW'(1);
                if (i_q == CW'(WIDTH - 1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                result_d = no_borrow ? diff[WIDTH-1:0] : r_q[WIDTH-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            i_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            r_q      <= r_d;
            i_q      <= i_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_montgomery_mult_serial.sv
// tb/tb_montgomery_mult_serial.sv - directed self-checking bench for montgomery_mult_serial
module tb_montgomery_mult_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b, n;
    logic       busy, done, err;
    logic [7:0] result;

    int n_tests;
    int n_fail;

    montgomery_mult_serial #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Call at the negedge following the accepting edge; counts further edges until done.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] in_,
                          output logic [7:0] res, output int lat, output logic e, output logic bsy);
        @(negedge clk);
        a = ia; b = ib; n = in_; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bsy = busy;
        wait_done(lat);
        res = result;
        e   = err;
    endtask

    logic [7:0] res;
    int         lat;
    logic       e;
    logic       bsy;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; n = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_result", result, 0);
        rst_n = 1'b1;

        // 1. 5*7*2^-8 mod 13 = 1
        run_op(8'd5, 8'd7, 8'd13, res, lat, e, bsy);
        check_eq("t1_busy", bsy, 1);
        check_eq("t1_lat", lat, 9);
        check_eq("t1_result", res, 1);
        check_eq("t1_err", e, 0);
        @(negedge clk);
        check_eq("t1_done_pulse", done, 0);
        check_eq("t1_busy_after", busy, 0);

        // 2. small vectors
        run_op(8'd1, 8'd1, 8'd13, res, lat, e, bsy);
        check_eq("t2a_result", res, 3);
        check_eq("t2a_lat", lat, 9);
        run_op(8'd0, 8'd9, 8'd13, res, lat, e, bsy);
        check_eq("t2b_result", res, 0);

        // 3. max width, final subtract path
        run_op(8'd254, 8'd254, 8'd255, res, lat, e, bsy);
        check_eq("t3_result", res, 1);
        check_eq("t3_lat", lat, 9);

        // 4. mid-op start ignored, then back-to-back on done cycle
        @(negedge clk);
        a = 8'd5; b = 8'd7; n = 8'd13; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'd1; b = 8'd1; n = 8'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check_eq("t4_first_lat", lat + 4, 9);
        check_eq("t4_first_result", result, 1);
        check_eq("t4_first_done", done, 1);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("t4_second_busy", busy, 1);
        wait_done(lat);
        check_eq("t4_second_lat", lat, 9);
        check_eq("t4_second_result", result, 3);

        // 5. reset during LOOP cycle 4
        @(negedge clk);
        a = 8'd5; b = 8'd7; n = 8'd13; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_done", done, 0);
        check_eq("t5_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd1, 8'd1, 8'd13, res, lat, e, bsy);
        check_eq("t5_fresh_result", res, 3);
        check_eq("t5_fresh_lat", lat, 9);

        // 6. even modulus
        run_op(8'd5, 8'd7, 8'd12, res, lat, e, bsy);
`ifdef MONT_MOD_CHECK_EN
        check_eq("t6_lat", lat, 0);
        check_eq("t6_err", e, 1);
        check_eq("t6_result", res, 0);
        check_eq("t6_busy", bsy, 0);
`else
        check_eq("t6_lat", lat, 9);
        check_eq("t6_err", e, 0);
`endif
        @(negedge clk);
        check_eq("t6_err_clear", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
